// File: rtl/regfile_wb_scheduler_if.sv
// Writeback, register-file write port and issue/scoreboard signals of the
// writeback scheduler, bundled for connection between the datapath and the
// scheduler. The scheduler takes the slave view; execution units, decode and
// the register file together form the master view.
interface regfile_wb_scheduler_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 64
);
  // Writeback requesters
  logic [NUM_REQ-1:0]      req_valid;
  logic [5*NUM_REQ-1:0]    req_rd;
  logic [XLEN*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;

  // Register file write port
  logic                    reg_write;
  logic [4:0]              rd_addr;
  logic [XLEN-1:0]         rd_data;

  // Decode/issue and hazard lookup
  logic                    issue_valid;
  logic [4:0]              issue_rd;
  logic                    issue_ready;
  logic [4:0]              rs1_addr;
  logic [4:0]              rs2_addr;
  logic                    rs1_busy;
  logic                    rs2_busy;

  modport master (
    output req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    input  req_ready, reg_write, rd_addr, rd_data, issue_ready, rs1_busy, rs2_busy
  );

  modport slave (
    input  req_valid, req_rd, req_data, issue_valid, issue_rd, rs1_addr, rs2_addr,
    output req_ready, reg_write, rd_addr, rd_data, issue_ready, rs1_busy, rs2_busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32 x XLEN integer register file.
// - Round-robin arbitration of NUM_REQ writeback requesters onto the single
//   write port; the port itself is driven from registers.
// - Busy scoreboard: set on issue of an instruction writing rd, cleared on
//   the edge at which the register file commits that rd.
// Optional feature: define RF_WB_TRACE_EN to print one line per committed
// writeback (the granted requester index is then carried with the data).
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 64
) (
  input logic                    clk,
  input logic                    rst,
  regfile_wb_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;

  logic [4:0]         sel_rd;
  logic [XLEN-1:0]    sel_data;

  logic               reg_write_q, reg_write_d;
  logic [4:0]         rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]    rd_data_q, rd_data_d;

  logic [31:0]        busy_q, busy_d;
  logic               issue_ok;

  // Round-robin search starting one past the last grant; no grants in reset.
  always_comb begin
    int cand;
    logic [IDX_W-1:0] cand_idx;
    gnt      = '0;
    gnt_idx  = last_q;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (!rst) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        cand     = (int'(last_q) + k) % NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!gnt_any && bus.req_valid[cand_idx]) begin
          gnt_any       = 1'b1;
          gnt[cand_idx] = 1'b1;
          gnt_idx       = cand_idx;
        end
      end
    end
    last_d = gnt_any ? gnt_idx : last_q;
  end

  // Mux the granted requester's destination and data; one-hot grant so OR works.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = sel_rd   | bus.req_rd[5*i +: 5];
        sel_data = sel_data | bus.req_data[XLEN*i +: XLEN];
      end
    end
    // Writes to x0 are accepted but never reach the port.
    reg_write_d = gnt_any && (sel_rd != 5'd0);
    rd_addr_d   = reg_write_d ? sel_rd   : rd_addr_q;
    rd_data_d   = reg_write_d ? sel_data : rd_data_q;
  end

  // Arbitration pointer and registered write-port drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q      <= LAST_RST;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      last_q      <= last_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Issue acceptance and scoreboard next state; set and clear never collide
  // because a set requires the target to be idle.
  always_comb begin
    issue_ok = !rst && bus.issue_valid &&
               ((bus.issue_rd == 5'd0) || !busy_q[bus.issue_rd]);
    busy_d = busy_q;
    if (reg_write_q) busy_d[rd_addr_q] = 1'b0;
    if (issue_ok && (bus.issue_rd != 5'd0)) busy_d[bus.issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; reset drops every pending write.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign bus.req_ready   = gnt;
  assign bus.reg_write   = reg_write_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.issue_ready = issue_ok;
  assign bus.rs1_busy    = busy_q[bus.rs1_addr];
  assign bus.rs2_busy    = busy_q[bus.rs2_addr];

`ifdef RF_WB_TRACE_EN
  logic [IDX_W-1:0] wb_idx_q;

  // Carry the grant index with the write and report each commit.
  always_ff @(posedge clk) begin
    if (rst) wb_idx_q <= '0;
    else if (reg_write_d) wb_idx_q <= gnt_idx;
    if (!rst && reg_write_q)
      $display("WB: x%0d = %h (req %0d)", rd_addr_q, rd_data_q, wb_idx_q);
  end
`endif

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Schedules all writebacks into the 32 x 64-bit integer register file and tracks which architectural registers have a write in flight. Sits between the execution units (ALU, load unit, multiplier; NUM_REQ requesters) and the register file's single write port. Also sits beside the decode/issue stage, which it serves with a scoreboard. It provides round-robin sharing of the write port, a registered write-port drive, and busy flags for RAW/WAW hazard stalls.

## Interface
- NUM_REQ, 3, number of writeback requesters (2..8)
- XLEN, 64, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester writeback valid
- req_rd  in  5*NUM_REQ  destination register, requester i at [5i+4:5i]
- req_data  in  XLEN*NUM_REQ  writeback data, requester i at [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
- reg_write  out  1  register file write enable (registered)
- rd_addr  out  5  register file write address (registered)
- rd_data  out  XLEN  register file write data (registered)
- issue_valid  in  1  decode wants to issue an instruction writing issue_rd
- issue_rd  in  5  destination of issuing instruction
- issue_ready  out  1  issue accepted this cycle (combinational)
- rs1_addr, rs2_addr  in  5 each  source registers being decoded
- rs1_busy, rs2_busy  out  1 each  source has a pending write (combinational)

## Operation
- Arbitration:
  - Round-robin pointer `last` (log2 NUM_REQ bits) holds the index of the last grant.
  - Search starts at last+1, wrapping modulo NUM_REQ.
  - At most one req_ready bit is high per cycle.
  - req_ready[i] is high only if req_valid[i] is high.
  - `last` updates to the granted index on each transfer.
  - With no request, `last` holds.
- Output stage:
  - On a transfer with req_rd != 0: reg_write <= 1, rd_addr <= req_rd, rd_data <= req_data at the next edge.
  - Otherwise reg_write <= 0; rd_addr and rd_data hold.
  - A transfer to x0 is accepted and discarded.
  - The write port is never backpressured, so one transfer per cycle is sustained.
- Scoreboard: `busy[31:0]`; busy[0] is constant 0.
  - issue_ready = issue_valid && (issue_rd == 0 || !busy[issue_rd]).
  - When issue_ready is high and issue_rd != 0, busy[issue_rd] <= 1.
  - When reg_write is high, busy[rd_addr] <= 0 at that edge. This is the same edge at which the register file commits the data.
  - A set and a clear can never target the same register in the same cycle, because a set requires the register to be not busy.
  - rsN_busy = busy[rsN_addr].
- Reset (rst high at an edge):
  - busy cleared; `last` = NUM_REQ-1, so requester 0 has first priority; reg_write = 0; rd_addr = 0; rd_data = 0.
  - While rst is high, req_ready = 0 and issue_ready = 0.
  - A writeback registered but not yet committed is dropped. The register file is reset in the same cycle.
- Requesters must hold req_valid, req_rd and req_data stable until the transfer completes.

## Timing
- Grant and issue_ready: combinational in the request cycle T.
- Write-port drive: valid in cycle T+1; register file contents updated at the end of T+1.
- Busy: cleared at the end of T+1, so rsN_busy is low from cycle T+2. A source read combinationally in T+2 sees the new value.
- Issue-to-busy: issue in cycle T gives rsN_busy high from cycle T+1.
- Worst-case wait for a held request: NUM_REQ-1 cycles.

## Configuration
- RF_WB_TRACE_EN defined: on every cycle with reg_write high, prints "WB: x<rd_addr> = <rd_data hex> (req <index>)". This requires the granted index to be registered alongside the data.
- RF_WB_TRACE_EN undefined: no trace logic or display statements. All port behaviour is identical.

## Test plan
- Reset, then req_valid=3'b111, rd=1/2/3, data=A/B/C held, deasserting each after its transfer:
  - grants are requester 0, then 1, then 2;
  - reg_write with x1=A, x2=B, x3=C in cycles T+1..T+3.
- Requesters 0 and 2 valid continuously:
  - grants alternate 0,2,0,2;
  - requester 1 raises mid-stream and is granted within 2 cycles.
- issue_rd=5 in cycle 0 then a writeback to x5 in cycle 3:
  - rs1_addr=5 gives rs1_busy=1 in cycles 1..4 and 0 in cycle 5;
  - a second issue to x5 in cycle 2 has issue_ready=0.
- Request with rd=0, data=FFFF:
  - req_ready=1;
  - reg_write stays 0;
  - issue_rd=0 gives issue_ready=1 and no busy bit set.
- Assert rst the cycle after a transfer to x7 with busy[7]=1:
  - next cycle reg_write=0;
  - busy all 0;
  - the following grant goes to requester 0.
- Issue x9 and a writeback clearing x4 in the same cycle:
  - busy[9]=1 and busy[4]=0 after the edge.
